// File: rtl/seg7_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_ctrl_pkg
// Description : Shared types and constants for the 7-segment scan controller.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_scan_ctrl_pkg;

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_e;

    // All outputs are active-low, so "off" is all ones.
    localparam logic [6:0]  SEG_OFF = 7'b1111111;
    localparam logic [31:0] AN_OFF  = 32'hFFFF_FFFF;

    // Segment order {g,f,e,d,c,b,a}; entry 0 is the rightmost element.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

endpackage
`default_nettype wire

// File: rtl/seg7_scan_ctrl_hex_dec.sv
`default_nettype none
// ============================================================================
// Module      : seg7_hex_dec
// Description : Combinational hex nibble to active-low 7-segment decode.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_hex_dec
    import seg7_scan_ctrl_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX_SEG[hex_i];

endmodule
`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_ctrl
// Description : Time-multiplexed scan controller for a common-anode display.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_ctrl
    import seg7_scan_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int ON_CYC     = 50000,
    parameter int BLANK_CYC  = 500
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value_i,
    input  logic [NUM_DIGITS-1:0]   dp_in_i,
    input  logic [NUM_DIGITS-1:0]   dig_en_i,
    input  logic                    load_i,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic [6:0]              seg_o,
    output logic                    dp_o,
    output logic                    frame_done_o
);

    localparam int CNT_MAX = (ON_CYC > BLANK_CYC) ? ON_CYC : BLANK_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0]      ON_LAST    = CNT_W'(ON_CYC - 1);
    localparam logic [CNT_W-1:0]      BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [NUM_DIGITS-1:0] AN_ALL_OFF = AN_OFF[NUM_DIGITS-1:0];

    scan_state_e             state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] hold_val_q, hold_val_d, shd_val_q, shd_val_d;
    logic [NUM_DIGITS-1:0]   hold_dp_q, hold_dp_d, shd_dp_q, shd_dp_d;
    logic [NUM_DIGITS-1:0]   hold_en_q, hold_en_d, shd_en_q, shd_en_d;
    logic                    pending_q, pending_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic                    fdone_q, fdone_d;
    logic                    w_boundary;
    logic [3:0]              w_nibble;
    logic [6:0]              w_dec_seg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_BLANK;
            cnt_q      <= '0;
            idx_q      <= '0;
            hold_val_q <= '0;
            hold_dp_q  <= '0;
            hold_en_q  <= '0;
            shd_val_q  <= '0;
            shd_dp_q   <= '0;
            shd_en_q   <= '0;
            pending_q  <= 1'b0;
            an_q       <= AN_ALL_OFF;
            seg_q      <= SEG_OFF;
            dp_q       <= 1'b1;
            fdone_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            hold_val_q <= hold_val_d;
            hold_dp_q  <= hold_dp_d;
            hold_en_q  <= hold_en_d;
            shd_val_q  <= shd_val_d;
            shd_dp_q   <= shd_dp_d;
            shd_en_q   <= shd_en_d;
            pending_q  <= pending_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            fdone_q    <= fdone_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_W'(1);
        idx_d      = idx_q;
        w_boundary = 1'b0;
        case (state_q)
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_SHOW;
                    cnt_d   = '0;
                end
            end
            ST_SHOW: begin
                if (cnt_q == ON_LAST) begin
                    state_d    = ST_BLANK;
                    cnt_d      = '0;
                    w_boundary = (idx_q == IDX_LAST);
                    idx_d      = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = ST_BLANK;
                cnt_d   = '0;
            end
        endcase

        // Shadow only moves at a frame boundary; a load on that cycle wins.
        hold_val_d = hold_val_q;
        hold_dp_d  = hold_dp_q;
        hold_en_d  = hold_en_q;
        shd_val_d  = shd_val_q;
        shd_dp_d   = shd_dp_q;
        shd_en_d   = shd_en_q;
        pending_d  = pending_q;
        if (load_i) begin
            hold_val_d = value_i;
            hold_dp_d  = dp_in_i;
            hold_en_d  = dig_en_i;
            pending_d  = 1'b1;
        end
        if (w_boundary && load_i) begin
            shd_val_d = value_i;
            shd_dp_d  = dp_in_i;
            shd_en_d  = dig_en_i;
            pending_d = 1'b0;
        end else if (w_boundary && pending_q) begin
            shd_val_d = hold_val_q;
            shd_dp_d  = hold_dp_q;
            shd_en_d  = hold_en_q;
            pending_d = 1'b0;
        end
    end

    seg7_hex_dec u_hex_dec (
        .hex_i (w_nibble),
        .seg_o (w_dec_seg)
    );

    // Outputs are computed from the next state so they land on the same edge.
    always_comb begin
        w_nibble = 4'h0;
        an_d     = AN_ALL_OFF;
        seg_d    = SEG_OFF;
        dp_d     = 1'b1;
        fdone_d  = (state_d == ST_SHOW) && (cnt_d == ON_LAST) && (idx_d == IDX_LAST);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_d == IDX_W'(i)) begin
                w_nibble = shd_val_q[4*i +: 4];
                if (state_d == ST_SHOW && shd_en_q[i]) begin
                    an_d[i] = 1'b0;
                    seg_d   = w_dec_seg;
                    dp_d    = ~shd_dp_q[i];
                end
            end
        end
    end

    assign an_o         = an_q;
    assign seg_o        = seg_q;
    assign dp_o         = dp_q;
    assign frame_done_o = fdone_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_ctrl
// Description : Randomized self-checking bench with a frame-position model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_ctrl;

    localparam int ND    = 4;
    localparam int ON    = 4;
    localparam int BL    = 2;
    localparam int SLOT  = ON + BL;
    localparam int FRAME = ND * SLOT;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  dig_en = '0;
    logic        load = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(
        .NUM_DIGITS (ND),
        .ON_CYC     (ON),
        .BLANK_CYC  (BL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .value_i      (value),
        .dp_in_i      (dp_in),
        .dig_en_i     (dig_en),
        .load_i       (load),
        .an_o         (an),
        .seg_o        (seg),
        .dp_o         (dp),
        .frame_done_o (frame_done)
    );

    logic [6:0] seg_ref [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    int errors = 0;
    int checks = 0;

    // Reference state: cycles since reset release plus the displayed/held data.
    int          k;
    logic [15:0] m_val, h_val;
    logic [3:0]  m_dp, m_en, h_dp, h_en;
    bit          m_pend;
    logic [15:0] seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t k=%0d)", tag, obs, exp, $time, k);
        end
    endtask

    task automatic model_clear();
        k = 0;
        m_val = '0; m_dp = '0; m_en = '0;
        h_val = '0; h_dp = '0; h_en = '0;
        m_pend = 1'b0;
    endtask

    task automatic check_outputs();
        int pos, d;
        bit show;
        logic [3:0] e_an, nib;
        logic [6:0] e_seg;
        logic       e_dp;
        pos   = k % FRAME;
        d     = pos / SLOT;
        show  = (pos % SLOT) >= BL;
        e_an  = 4'hF;
        e_seg = 7'h7F;
        e_dp  = 1'b1;
        if (show && m_en[d]) begin
            nib      = m_val[4*d +: 4];
            e_an[d]  = 1'b0;
            e_seg    = seg_ref[nib];
            e_dp     = ~m_dp[d];
        end
        chk("an", 32'(an), 32'(e_an));
        chk("seg", 32'(seg), 32'(e_seg));
        chk("dp", 32'(dp), 32'(e_dp));
        chk("frame_done", 32'(frame_done), 32'(pos == FRAME - 1));
        for (int c = 0; c < 16; c++)
            if (show && an != 4'hF && seg == seg_ref[c]) seen[c] = 1'b1;
    endtask

    // One clock: check current outputs, drive inputs, advance the model.
    task automatic cyc(input bit ld, input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
        bit bnd;
        check_outputs();
        load = ld; value = v; dp_in = d; dig_en = e;
        bnd = (k % FRAME) == FRAME - 1;
        if (ld && bnd) begin
            h_val = v; h_dp = d; h_en = e;
            m_val = v; m_dp = d; m_en = e;
            m_pend = 1'b0;
        end else if (ld) begin
            h_val = v; h_dp = d; h_en = e;
            m_pend = 1'b1;
        end else if (bnd && m_pend) begin
            m_val = h_val; m_dp = h_dp; m_en = h_en;
            m_pend = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        k++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cyc(1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
    endtask

    task automatic run_to(input int p);
        for (int i = 0; i < FRAME && (k % FRAME) != p; i++) idle(1);
    endtask

    // Assert reset between edges and confirm outputs clear without a clock.
    task automatic do_reset();
        load = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dp", 32'(dp), 32'h1);
        chk("rst_fdone", 32'(frame_done), 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_hold_an", 32'(an), 32'hF);
        rst = 1'b0;
        model_clear();
    endtask

    initial begin
        logic [15:0] sweep [4] = '{16'h3210, 16'h7654, 16'hBA98, 16'hFEDC};
        seen = '0;
        model_clear();
        @(negedge clk);
        do_reset();
        idle(FRAME + 3);

        // Basic scan of 12AF with DP on digit 2.
        cyc(1'b1, 16'h12AF, 4'b0100, 4'b1111);
        run_to(0);
        idle(2 * FRAME);

        // Load at the start of digit-1 SHOW must not tear the current frame.
        run_to(SLOT + BL);
        cyc(1'b1, 16'h0000, 4'b0000, 4'b1111);
        idle(2 * FRAME);

        // Digit 3 blanked.
        cyc(1'b1, 16'h5678, 4'b0001, 4'b0111);
        idle(2 * FRAME + 5);

        // Load exactly on the frame_done cycle.
        run_to(FRAME - 1);
        cyc(1'b1, 16'h8888, 4'b0000, 4'b1111);
        idle(2 * FRAME);

        seen = '0;
        for (int s = 0; s < 4; s++) begin
            run_to(3);
            cyc(1'b1, sweep[s], 4'($urandom), 4'b1111);
            idle(2 * FRAME);
        end
        chk("codes_seen", 32'(seen), 32'hFFFF);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0)
                cyc(1'b1, 16'($urandom), 4'($urandom), 4'($urandom));
            else
                idle(1);
        end

        // Reset in the middle of a SHOW interval, then resume random traffic.
        run_to(2 * SLOT + BL + 1);
        do_reset();
        idle(FRAME);
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 7) == 0)
                cyc(1'b1, 16'($urandom), 4'($urandom), 4'($urandom));
            else
                idle(1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
